// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and limits for the Wishbone bus arbiters
package wb_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int MAX_MASTERS = 8;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick of the first requester after ptr
module rr_picker #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    int cand;

    // Scan from the farthest candidate down so the nearest one after ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = (int'(ptr) + k) % NUM_MASTERS;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/wb_timer_arbiter.sv
// rtl/wb_timer_arbiter.sv - round-robin Wishbone arbiter in front of the machine-timer slave
module wb_timer_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS-1:0]         m_cyc,
    input  logic [NUM_MASTERS-1:0]         m_stb,
    input  logic [NUM_MASTERS-1:0]         m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0]   m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0]   m_wdat,
    output logic [DAT_W-1:0]               m_rdat,
    output logic [NUM_MASTERS-1:0]         m_ack,
    output logic [NUM_MASTERS-1:0]         m_err,
    output logic                           s_cyc,
    output logic                           s_stb,
    output logic                           s_we,
    output logic [ADR_W-1:0]               s_adr,
    output logic [DAT_W-1:0]               s_wdat,
    input  logic [DAT_W-1:0]               s_rdat,
    input  logic                           s_ack,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    int               o;

    rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_picker (
        .req  (m_cyc & m_stb),
        .ptr  (rr_ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= IDX_W'(NUM_MASTERS - 1);
            wd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            wd_cnt <= wd_cnt_nxt;
        end
    end

    assign m_rdat    = s_rdat;
    assign grant_idx = owner;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        wd_cnt_nxt = wd_cnt;
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_adr      = '0;
        s_wdat     = '0;
        m_ack      = '0;
        m_err      = '0;
        o          = int'(owner);

        unique case (state)
            ARB_IDLE: begin
                wd_cnt_nxt = '0;
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                s_cyc    = m_cyc[o];
                s_stb    = m_stb[o];
                s_we     = m_we[o];
                s_adr    = m_adr[o*ADR_W +: ADR_W];
                s_wdat   = m_wdat[o*DAT_W +: DAT_W];
                m_ack[o] = s_ack & m_cyc[o];
                // Releasing CYC always passes through IDLE, so no master is handed the bus directly.
                if (!m_cyc[o]) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = owner;
                    wd_cnt_nxt = '0;
                end else if (s_stb && !s_ack) begin
                    if (wd_cnt == WD_LAST) begin
                        m_err[o]   = 1'b1;
                        wd_cnt_nxt = '0;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 1'b1;
                    end
                end else begin
                    wd_cnt_nxt = '0;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule
